pipeline_ctrl: RTL and testbench
================================

# pipeline_ctrl

Central stall/flush sequencer for the five-stage pipeline. It decides each cycle whether the IF/ID, ID/EX, EX/MEM and MEM/WB registers advance, hold or flush, and whether the PC updates. It also masks the data-memory request after completion, so an access satisfied while the fetch is still pending is not reissued. It sits beside the pipeline registers and drives their `enable_*` / `flush_*` inputs from cache hit signals, hazard information from ID/EX and EX/MEM, branch resolution and halt.

## Interface
Parameters:
- `STALL_CNT_W`, default 16: width of the saturating stall-cycle counter.

Ports:
- `CLK`, input, 1: single clock, rising edge.
- `RST`, input, 1: synchronous, active-high reset.
- `ihit`, input, 1: instruction fetch completes this cycle.
- `dhit`, input, 1: data access completes this cycle.
- `dREN_EX_MEM`, input, 1: load is in EX/MEM.
- `dWEN_EX_MEM`, input, 1: store is in EX/MEM.
- `halt_EX_MEM`, input, 1: halt is in EX/MEM.
- `dREN_ID_EX`, input, 1: load is in ID/EX.
- `Rt_ID_EX`, input, 5: destination of the load in ID/EX.
- `Rs_IF_ID`, input, 5: source register of the instruction in IF/ID.
- `Rt_IF_ID`, input, 5: source register of the instruction in IF/ID.
- `branch_taken`, input, 1: branch or jump resolved taken in EX.
- `enable_IF_ID`, `enable_ID_EX`, `enable_EX_MEM`, `enable_MEM_WB`, output, 1 each: register advance strobes.
- `flush_IF_ID`, `flush_ID_EX`, `flush_EX_MEM`, output, 1 each: load a bubble on the next edge. Only meaningful with the matching enable.
- `pc_en`, output, 1: PC update strobe.
- `dmemREN`, `dmemWEN`, output, 1 each: masked data requests to the cache.
- `halt`, output, 1: sticky halt to the system.
- `stall_count`, output, `STALL_CNT_W`: saturating count of stalled cycles.

## Operation
State machine `ctrl_state_t` has three states: RUN, D_DONE and HALTED.

Derived signals:
- `dreq = dREN_EX_MEM | dWEN_EX_MEM`.
- `mem_ok = !dreq | dhit | (state == D_DONE)`.
- `advance = (state != HALTED) & ihit & mem_ok`.
- `load_use = dREN_ID_EX & (Rt_ID_EX != 0) & (Rt_ID_EX == Rs_IF_ID | Rt_ID_EX == Rt_IF_ID)`.

Transitions:
- RUN → D_DONE when `dreq & dhit & !ihit`.
- RUN → HALTED when `advance & halt_EX_MEM`.
- D_DONE → RUN when `ihit`; D_DONE → HALTED when `ihit & halt_EX_MEM`.
- HALTED is terminal until `RST`.

Outputs (Mealy, combinational from state and inputs):
- When `!advance`: all enables are 0, all flushes are 0 and `pc_en` = 0, so the whole pipeline holds.
- When `advance`: all four enables are 1 and `pc_en` = 1. Modifiers are applied in priority order:
  1. `branch_taken`: `flush_IF_ID` = 1 and `flush_ID_EX` = 1. `pc_en` = 1 so the PC loads the target. `load_use` is ignored.
  2. else `load_use`: `enable_IF_ID` = 0, `pc_en` = 0, `flush_ID_EX` = 1, inserting one bubble.
  3. `halt_EX_MEM`: `flush_EX_MEM` = 1, so the halt does not re-enter MEM. MEM/WB still captures the halt.
- `dmemREN = dREN_EX_MEM & (state == RUN)`; `dmemWEN = dWEN_EX_MEM & (state == RUN)`. Both are 0 in D_DONE and HALTED.
- `halt` is 1 in HALTED, otherwise 0.
- `stall_count` increments each cycle with `state != HALTED & !advance`, saturates at all-ones, and holds in HALTED.

Boundary conditions:
- `ihit & dhit` in the same cycle from RUN: advance directly, stay in RUN.
- `dhit` with `!dreq` is ignored.
- `branch_taken` and `load_use` together: the branch wins.
- `RST` mid-stall or mid-D_DONE: next state is RUN and the counter clears.

## Timing
- Reset: while `RST` is high, all enables are 0, all flushes are 1, and `pc_en`, `dmemREN`, `dmemWEN`, `halt` are 0. On the clock edge with `RST` high, the state becomes RUN and `stall_count` becomes 0.
- Zero-cycle latency from `ihit` / `dhit` to the enables (combinational). State and counter update on the `CLK` edge.
- A load-use hazard costs exactly one advancing cycle of bubble. A taken branch costs two flushed slots.
- `halt` asserts the cycle after `advance & halt_EX_MEM`.

## Structure
- Shared package `pipeline_ctrl_pkg`: `ctrl_state_t` enum {RUN, D_DONE, HALTED}.
- One sub-module, `hazard_detect`, computes `load_use` combinationally. The FSM, output decode and counter stay in `pipeline_ctrl`.
- Interface `pipeline_ctrl_if` with modports `ctrl` and `tb`.

## Test plan
- Steady RUN with `ihit` = 1 and `dreq` = 0 for 5 cycles → all enables 1, `pc_en` = 1, `stall_count` = 0.
- Load with `dhit` at cycle 3 and `ihit` at cycle 5 → state is D_DONE on cycles 4–5 with `dmemREN` = 0; advance on cycle 5; `stall_count` = 4.
- `dREN_ID_EX` = 1, `Rt_ID_EX` = 8, `Rs_IF_ID` = 8, `ihit` = 1 → `enable_IF_ID` = 0, `pc_en` = 0, `flush_ID_EX` = 1. Repeat with `Rt_ID_EX` = 0 → no stall.
- `branch_taken` and `load_use` together with `ihit` → `flush_IF_ID` = 1, `flush_ID_EX` = 1, `pc_en` = 1.
- `halt_EX_MEM` with advance → `flush_EX_MEM` = 1; next cycle `halt` = 1 and all enables 0 thereafter.
- Assert `RST` while in D_DONE with `stall_count` = 7 → next cycle state is RUN and `stall_count` = 0; saturation check with `STALL_CNT_W` = 4 holds at 15.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer.
package pipeline_ctrl_pkg;

  // RUN: normal flow. D_DONE: data access already satisfied, waiting on
  // the fetch. HALTED: terminal until reset.
  typedef enum logic [1:0] {
    RUN    = 2'd0,
    D_DONE = 2'd1,
    HALTED = 2'd2
  } ctrl_state_t;

  // Register zero never carries a real dependency.
  localparam logic [4:0] ZERO_REG = 5'd0;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Handshake bundle between the sequencer and the pipeline registers/caches.
interface pipeline_ctrl_if #(parameter int STALL_CNT_W = 16);

  logic                   ihit;
  logic                   dhit;
  logic                   dREN_EX_MEM;
  logic                   dWEN_EX_MEM;
  logic                   halt_EX_MEM;
  logic                   dREN_ID_EX;
  logic [4:0]             Rt_ID_EX;
  logic [4:0]             Rs_IF_ID;
  logic [4:0]             Rt_IF_ID;
  logic                   branch_taken;

  logic                   enable_IF_ID;
  logic                   enable_ID_EX;
  logic                   enable_EX_MEM;
  logic                   enable_MEM_WB;
  logic                   flush_IF_ID;
  logic                   flush_ID_EX;
  logic                   flush_EX_MEM;
  logic                   pc_en;
  logic                   dmemREN;
  logic                   dmemWEN;
  logic                   halt;
  logic [STALL_CNT_W-1:0] stall_count;

  modport ctrl (
    input  ihit, dhit, dREN_EX_MEM, dWEN_EX_MEM, halt_EX_MEM, dREN_ID_EX,
           Rt_ID_EX, Rs_IF_ID, Rt_IF_ID, branch_taken,
    output enable_IF_ID, enable_ID_EX, enable_EX_MEM, enable_MEM_WB,
           flush_IF_ID, flush_ID_EX, flush_EX_MEM, pc_en,
           dmemREN, dmemWEN, halt, stall_count
  );

  modport tb (
    output ihit, dhit, dREN_EX_MEM, dWEN_EX_MEM, halt_EX_MEM, dREN_ID_EX,
           Rt_ID_EX, Rs_IF_ID, Rt_IF_ID, branch_taken,
    input  enable_IF_ID, enable_ID_EX, enable_EX_MEM, enable_MEM_WB,
           flush_IF_ID, flush_ID_EX, flush_EX_MEM, pc_en,
           dmemREN, dmemWEN, halt, stall_count
  );

endinterface

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use hazard detection: a load in ID/EX whose destination feeds the
// instruction currently in IF/ID.
module hazard_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic       dREN_ID_EX,
  input  logic [4:0] Rt_ID_EX,
  input  logic [4:0] Rs_IF_ID,
  input  logic [4:0] Rt_IF_ID,
  output logic       load_use
);

  // Register zero is hardwired, so a load targeting it creates no hazard.
  always_comb begin
    load_use = dREN_ID_EX && (Rt_ID_EX != ZERO_REG) &&
               ((Rt_ID_EX == Rs_IF_ID) || (Rt_ID_EX == Rt_IF_ID));
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush sequencer: drives the pipeline register enables and
// flushes, the PC strobe, masked data requests, sticky halt and a stall
// counter.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int STALL_CNT_W = 16
)
(
  input logic           CLK,
  input logic           RST,
  pipeline_ctrl_if.ctrl bus
);

  ctrl_state_t            state_q;
  ctrl_state_t            next_state;
  logic [STALL_CNT_W-1:0] stall_cnt_q;
  logic                   dreq;
  logic                   mem_ok;
  logic                   advance;
  logic                   load_use;

  assign dreq    = bus.dREN_EX_MEM | bus.dWEN_EX_MEM;
  assign mem_ok  = ~dreq | bus.dhit | (state_q == D_DONE);
  assign advance = (state_q != HALTED) & bus.ihit & mem_ok;

  hazard_detect u_hazard_detect (
    .dREN_ID_EX (bus.dREN_ID_EX),
    .Rt_ID_EX   (bus.Rt_ID_EX),
    .Rs_IF_ID   (bus.Rs_IF_ID),
    .Rt_IF_ID   (bus.Rt_IF_ID),
    .load_use   (load_use)
  );

  // State register; reset always returns to RUN.
  always_ff @(posedge CLK) begin
    if (RST) state_q <= RUN;
    else     state_q <= next_state;
  end

  // Next state: remember a satisfied data access while the fetch is still
  // pending, and latch halt once it has advanced out of EX/MEM.
  always_comb begin
    next_state = state_q;
    unique case (state_q)
      RUN: begin
        if (advance && bus.halt_EX_MEM)            next_state = HALTED;
        else if (dreq && bus.dhit && !bus.ihit)    next_state = D_DONE;
      end
      D_DONE: begin
        if (bus.ihit) next_state = bus.halt_EX_MEM ? HALTED : RUN;
      end
      HALTED:  next_state = HALTED;
      default: next_state = RUN;
    endcase
  end

  // Output decode: hold everything unless advancing, then apply branch,
  // load-use and halt modifiers; reset forces bubbles everywhere.
  always_comb begin
    bus.enable_IF_ID  = 1'b0;
    bus.enable_ID_EX  = 1'b0;
    bus.enable_EX_MEM = 1'b0;
    bus.enable_MEM_WB = 1'b0;
    bus.flush_IF_ID   = 1'b0;
    bus.flush_ID_EX   = 1'b0;
    bus.flush_EX_MEM  = 1'b0;
    bus.pc_en         = 1'b0;
    bus.dmemREN       = 1'b0;
    bus.dmemWEN       = 1'b0;
    bus.halt          = 1'b0;
    if (RST) begin
      bus.flush_IF_ID  = 1'b1;
      bus.flush_ID_EX  = 1'b1;
      bus.flush_EX_MEM = 1'b1;
    end else begin
      bus.dmemREN = bus.dREN_EX_MEM & (state_q == RUN);
      bus.dmemWEN = bus.dWEN_EX_MEM & (state_q == RUN);
      bus.halt    = (state_q == HALTED);
      if (advance) begin
        bus.enable_IF_ID  = 1'b1;
        bus.enable_ID_EX  = 1'b1;
        bus.enable_EX_MEM = 1'b1;
        bus.enable_MEM_WB = 1'b1;
        bus.pc_en         = 1'b1;
        if (bus.branch_taken) begin
          bus.flush_IF_ID = 1'b1;
          bus.flush_ID_EX = 1'b1;
        end else if (load_use) begin
          bus.enable_IF_ID = 1'b0;
          bus.pc_en        = 1'b0;
          bus.flush_ID_EX  = 1'b1;
        end
        if (bus.halt_EX_MEM) bus.flush_EX_MEM = 1'b1;
      end
    end
  end

  // Saturating count of cycles the pipeline spent held while not halted.
  always_ff @(posedge CLK) begin
    if (RST)
      stall_cnt_q <= '0;
    else if ((state_q != HALTED) && !advance && (stall_cnt_q != '1))
      stall_cnt_q <= stall_cnt_q + 1'b1;
  end

  assign bus.stall_count = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios plus a random
// run, all compared against a behavioural model of the sequencer.
module tb_pipeline_ctrl;

  typedef struct packed {
    logic       rst;
    logic       ihit;
    logic       dhit;
    logic       dren_mem;
    logic       dwen_mem;
    logic       halt_mem;
    logic       dren_idex;
    logic [4:0] rt_idex;
    logic [4:0] rs_ifid;
    logic [4:0] rt_ifid;
    logic       branch;
  } stim_t;

  logic CLK;
  logic RST;
  logic RST4;

  int checks   = 0;
  int failures = 0;

  // Model state: is the current data access already satisfied, is the
  // machine halted, how many cycles have stalled so far.
  bit m_mem_done;
  bit m_halted;
  int m_stalls;

  pipeline_ctrl_if #(.STALL_CNT_W(16)) bus ();
  pipeline_ctrl_if #(.STALL_CNT_W(4))  bus4 ();

  pipeline_ctrl #(.STALL_CNT_W(16)) dut (.CLK(CLK), .RST(RST), .bus(bus));
  pipeline_ctrl #(.STALL_CNT_W(4))  dut4 (.CLK(CLK), .RST(RST4), .bus(bus4));

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic stim_t idle_stim();
    stim_t s;
    s = '0;
    return s;
  endfunction

  task automatic applyStimulus(input stim_t s);
    RST              = s.rst;
    bus.ihit         = s.ihit;
    bus.dhit         = s.dhit;
    bus.dREN_EX_MEM  = s.dren_mem;
    bus.dWEN_EX_MEM  = s.dwen_mem;
    bus.halt_EX_MEM  = s.halt_mem;
    bus.dREN_ID_EX   = s.dren_idex;
    bus.Rt_ID_EX     = s.rt_idex;
    bus.Rs_IF_ID     = s.rs_ifid;
    bus.Rt_IF_ID     = s.rt_ifid;
    bus.branch_taken = s.branch;
  endtask

  // A cycle makes progress when not halted, the fetch is done and any data
  // access in MEM is done now or was done earlier.
  function automatic bit model_advance(input stim_t s);
    bit data_pending;
    data_pending = (s.dren_mem || s.dwen_mem) && !s.dhit && !m_mem_done;
    return !m_halted && s.ihit && !data_pending;
  endfunction

  // Expected outputs packed as {en x4, flush x3, pc_en, dmemREN, dmemWEN, halt}.
  function automatic logic [10:0] model_expect(input stim_t s);
    logic [3:0] en;
    logic [2:0] fl;
    logic       pc;
    bit         hazard;
    if (s.rst) return 11'b0000_111_0_0_0_0;
    en = 4'b0000;
    fl = 3'b000;
    pc = 1'b0;
    hazard = s.dren_idex && (s.rt_idex != 0) &&
             ((s.rt_idex == s.rs_ifid) || (s.rt_idex == s.rt_ifid));
    if (model_advance(s)) begin
      en = 4'b1111;
      pc = 1'b1;
      if (s.branch) fl[2:1] = 2'b11;
      else if (hazard) begin
        en[3] = 1'b0;
        pc    = 1'b0;
        fl[1] = 1'b1;
      end
      if (s.halt_mem) fl[0] = 1'b1;
    end
    return {en, fl, pc,
            s.dren_mem && !m_mem_done && !m_halted,
            s.dwen_mem && !m_mem_done && !m_halted,
            m_halted};
  endfunction

  task automatic model_update(input stim_t s);
    if (s.rst) begin
      m_mem_done = 0;
      m_halted   = 0;
      m_stalls   = 0;
    end else if (!m_halted) begin
      if (model_advance(s)) begin
        m_mem_done = 0;
        if (s.halt_mem) m_halted = 1;
      end else begin
        if (m_stalls < 65535) m_stalls++;
        if ((s.dren_mem || s.dwen_mem) && s.dhit) m_mem_done = 1;
      end
    end
  endtask

  function automatic logic [10:0] dut_vec();
    return {bus.enable_IF_ID, bus.enable_ID_EX, bus.enable_EX_MEM,
            bus.enable_MEM_WB, bus.flush_IF_ID, bus.flush_ID_EX,
            bus.flush_EX_MEM, bus.pc_en, bus.dmemREN, bus.dmemWEN, bus.halt};
  endfunction

  task automatic test_reset();
    stim_t s;
    logic [10:0] exp;
    for (int i = 0; i < 3; i++) begin
      s = stim_t'($urandom);
      s.rst = 1'b1;
      applyStimulus(s);
      #4;
      exp = model_expect(s);
      checks++;
      if (dut_vec() !== exp) begin
        failures++;
        $display("[TB] FAIL reset_outputs got=%b exp=%b", dut_vec(), exp);
      end
      model_update(s);
      @(posedge CLK); #1;
    end
    checks++;
    if (bus.stall_count !== 16'd0) begin
      failures++;
      $display("[TB] FAIL reset_stall_count got=%0d exp=0", bus.stall_count);
    end
  endtask

  task automatic test_steady_run();
    stim_t s;
    logic [10:0] exp;
    for (int i = 0; i < 5; i++) begin
      s = idle_stim();
      s.ihit = 1'b1;
      applyStimulus(s);
      #4;
      exp = model_expect(s);
      checks++;
      if (dut_vec() !== exp || exp !== 11'b1111_000_1_0_0_0) begin
        failures++;
        $display("[TB] FAIL steady_run got=%b exp=%b", dut_vec(), exp);
      end
      checks++;
      if (bus.stall_count !== 16'(m_stalls)) begin
        failures++;
        $display("[TB] FAIL steady_stall_count got=%0d exp=%0d", bus.stall_count, m_stalls);
      end
      model_update(s);
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_load_dhit();
    stim_t s;
    logic [10:0] exp;
    s = idle_stim();
    s.rst = 1'b1;
    applyStimulus(s);
    model_update(s);
    @(posedge CLK); #1;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      s = idle_stim();
      s.dren_mem = (cyc <= 5);
      s.dhit     = (cyc == 3);
      s.ihit     = (cyc >= 5);
      applyStimulus(s);
      #4;
      exp = model_expect(s);
      checks++;
      if (dut_vec() !== exp) begin
        failures++;
        $display("[TB] FAIL load_dhit cycle=%0d got=%b exp=%b", cyc, dut_vec(), exp);
      end
      if (cyc == 6) begin
        checks++;
        if (bus.stall_count !== 16'd4) begin
          failures++;
          $display("[TB] FAIL load_dhit_stalls got=%0d exp=4", bus.stall_count);
        end
      end
      model_update(s);
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_load_use();
    stim_t s;
    logic [10:0] exp;
    for (int k = 0; k < 3; k++) begin
      s = idle_stim();
      s.ihit      = 1'b1;
      s.dren_idex = 1'b1;
      s.rt_idex   = (k == 1) ? 5'd0 : 5'd8;
      s.rs_ifid   = (k == 2) ? 5'd3 : s.rt_idex;
      s.rt_ifid   = (k == 2) ? 5'd8 : 5'd5;
      applyStimulus(s);
      #4;
      exp = model_expect(s);
      checks++;
      if (dut_vec() !== exp) begin
        failures++;
        $display("[TB] FAIL load_use case=%0d got=%b exp=%b", k, dut_vec(), exp);
      end
      model_update(s);
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_branch_priority();
    stim_t s;
    logic [10:0] exp;
    s = idle_stim();
    s.ihit      = 1'b1;
    s.branch    = 1'b1;
    s.dren_idex = 1'b1;
    s.rt_idex   = 5'd9;
    s.rs_ifid   = 5'd9;
    applyStimulus(s);
    #4;
    exp = model_expect(s);
    checks++;
    if (dut_vec() !== exp) begin
      failures++;
      $display("[TB] FAIL branch_priority got=%b exp=%b", dut_vec(), exp);
    end
    model_update(s);
    @(posedge CLK); #1;
  endtask

  task automatic test_halt();
    stim_t s;
    logic [10:0] exp;
    for (int cyc = 0; cyc < 5; cyc++) begin
      s = idle_stim();
      s.ihit     = 1'b1;
      s.halt_mem = (cyc == 0);
      s.dren_mem = (cyc == 2);
      applyStimulus(s);
      #4;
      exp = model_expect(s);
      checks++;
      if (dut_vec() !== exp) begin
        failures++;
        $display("[TB] FAIL halt cycle=%0d got=%b exp=%b", cyc, dut_vec(), exp);
      end
      if (cyc > 0) begin
        checks++;
        if (bus.halt !== 1'b1 || bus.enable_MEM_WB !== 1'b0) begin
          failures++;
          $display("[TB] FAIL halt_sticky cycle=%0d got_halt=%b got_en=%b exp_halt=1 exp_en=0",
                   cyc, bus.halt, bus.enable_MEM_WB);
        end
      end
      checks++;
      if (bus.stall_count !== 16'(m_stalls)) begin
        failures++;
        $display("[TB] FAIL halt_stall_count got=%0d exp=%0d", bus.stall_count, m_stalls);
      end
      model_update(s);
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_reset_mid_ddone();
    stim_t s;
    logic [10:0] exp;
    for (int cyc = 0; cyc <= 10; cyc++) begin
      s = idle_stim();
      s.rst      = (cyc == 0) || (cyc == 9);
      s.dren_mem = (cyc != 0) && (cyc != 9);
      s.dhit     = (cyc == 7);
      applyStimulus(s);
      #4;
      exp = model_expect(s);
      checks++;
      if (dut_vec() !== exp) begin
        failures++;
        $display("[TB] FAIL reset_ddone cycle=%0d got=%b exp=%b", cyc, dut_vec(), exp);
      end
      if (cyc == 8 || cyc == 10) begin
        checks++;
        if (bus.stall_count !== ((cyc == 8) ? 16'd7 : 16'd0)) begin
          failures++;
          $display("[TB] FAIL reset_ddone_count cycle=%0d got=%0d exp=%0d",
                   cyc, bus.stall_count, (cyc == 8) ? 7 : 0);
        end
      end
      model_update(s);
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_random();
    stim_t s;
    logic [10:0] exp;
    for (int i = 0; i < 300; i++) begin
      s = idle_stim();
      s.rst       = ($urandom_range(0, 19) == 0);
      s.ihit      = ($urandom_range(0, 3) != 0);
      s.dhit      = $urandom_range(0, 1);
      s.dren_mem  = ($urandom_range(0, 3) == 0);
      s.dwen_mem  = ($urandom_range(0, 3) == 0);
      s.halt_mem  = ($urandom_range(0, 39) == 0);
      s.dren_idex = $urandom_range(0, 1);
      s.rt_idex   = 5'($urandom_range(0, 3));
      s.rs_ifid   = 5'($urandom_range(0, 3));
      s.rt_ifid   = 5'($urandom_range(0, 3));
      s.branch    = ($urandom_range(0, 4) == 0);
      applyStimulus(s);
      #4;
      exp = model_expect(s);
      checks++;
      if (dut_vec() !== exp) begin
        failures++;
        $display("[TB] FAIL random step=%0d got=%b exp=%b", i, dut_vec(), exp);
      end
      checks++;
      if (bus.stall_count !== 16'(m_stalls)) begin
        failures++;
        $display("[TB] FAIL random_stall_count step=%0d got=%0d exp=%0d", i, bus.stall_count, m_stalls);
      end
      model_update(s);
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_saturation();
    int exp_cnt;
    RST4 = 1'b1;
    @(posedge CLK); #1;
    RST4 = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge CLK); #1;
      exp_cnt = (i > 15) ? 15 : i;
      checks++;
      if (bus4.stall_count !== 4'(exp_cnt)) begin
        failures++;
        $display("[TB] FAIL saturation cycle=%0d got=%0d exp=%0d", i, bus4.stall_count, exp_cnt);
      end
    end
  endtask

  initial begin
    RST4 = 1'b1;
    bus4.ihit = 1'b0;         bus4.dhit = 1'b0;
    bus4.dREN_EX_MEM = 1'b0;  bus4.dWEN_EX_MEM = 1'b0;
    bus4.halt_EX_MEM = 1'b0;  bus4.dREN_ID_EX = 1'b0;
    bus4.Rt_ID_EX = 5'd0;     bus4.Rs_IF_ID = 5'd0;
    bus4.Rt_IF_ID = 5'd0;     bus4.branch_taken = 1'b0;
    m_mem_done = 0;
    m_halted   = 0;
    m_stalls   = 0;
    applyStimulus(idle_stim());
    #1;
    test_reset();
    test_steady_run();
    test_load_dhit();
    test_load_use();
    test_branch_priority();
    test_halt();
    test_reset_mid_ddone();
    test_random();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
